// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: runs cache fetch, register load, register read and multiplier wait for one command.
// Build option: define SEQ_TIMEOUT_EN to add a per-wait-state watchdog and the ERR state.
//
// state | meaning
// IDLE  | ready for a command
// F_REQ | cache_req high, waiting for synced cache_ack = 1
// F_REL | cache_req low, fetch controls held, waiting for synced cache_ack = 0
// L_REQ | reg_req high with write enables, waiting for synced reg_ack = 1
// L_REL | reg_req low, write controls held, waiting for synced reg_ack = 0
// R_REQ | reg_req high with read enables, waiting for synced reg_ack = 1
// R_REL | reg_req low, read controls held, waiting for synced reg_ack = 0
// MUL   | multiplier latency, exactly MUL_LAT cycles
// DONE  | one-cycle done pulse
// ERR   | watchdog expired, one-cycle err pulse (SEQ_TIMEOUT_EN only)
module mul_seq_ctrl #(
  parameter int address_size   = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int MUL_LAT        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [address_size-1:0] cmd_ra_1,
  input  logic [address_size-1:0] cmd_ra_2,
  input  logic [3:0]              cmd_wa_1,
  input  logic [3:0]              cmd_wa_2,
  output logic                    cache_req,
  input  logic                    cache_ack,
  output logic                    cache_re_1,
  output logic                    cache_re_2,
  output logic [address_size-1:0] cache_ra_1,
  output logic [address_size-1:0] cache_ra_2,
  output logic                    reg_req,
  input  logic                    reg_ack,
  output logic                    reg_we_1,
  output logic                    reg_we_2,
  output logic                    reg_re_1,
  output logic                    reg_re_2,
  output logic [3:0]              reg_wa_1,
  output logic [3:0]              reg_wa_2,
  output logic [3:0]              reg_ra_1,
  output logic [3:0]              reg_ra_2,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int MUL_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_F_REQ, S_F_REL, S_L_REQ, S_L_REL, S_R_REQ, S_R_REL, S_MUL, S_DONE
`ifdef SEQ_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  typedef struct packed {
    logic                    cmd_ready;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    cache_req;
    logic                    cache_re_1;
    logic                    cache_re_2;
    logic [address_size-1:0] cache_ra_1;
    logic [address_size-1:0] cache_ra_2;
    logic                    reg_req;
    logic                    reg_we_1;
    logic                    reg_we_2;
    logic                    reg_re_1;
    logic                    reg_re_2;
    logic [3:0]              reg_wa_1;
    logic [3:0]              reg_wa_2;
    logic [3:0]              reg_ra_1;
    logic [3:0]              reg_ra_2;
  } out_t;

  state_t                  r_state, w_state_nxt;
  logic                    w_accept;
  logic [SYNC_STAGES-1:0]  r_cache_sync, r_reg_sync;
  logic                    w_cache_ack_s, w_reg_ack_s;
  logic [MUL_W-1:0]        r_mul_cnt;
  logic [address_size-1:0] r_ra_1, r_ra_2, w_ra_1, w_ra_2;
  logic [3:0]              r_wa_1, r_wa_2;
  out_t                    r_out, w_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_sync <= '0;
      r_reg_sync   <= '0;
    end else begin
      r_cache_sync <= {r_cache_sync[SYNC_STAGES-2:0], cache_ack};
      r_reg_sync   <= {r_reg_sync[SYNC_STAGES-2:0], reg_ack};
    end
  end

  assign w_cache_ack_s = r_cache_sync[SYNC_STAGES-1];
  assign w_reg_ack_s   = r_reg_sync[SYNC_STAGES-1];

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_wait_st, w_timeout;

  assign w_wait_st = r_state inside {S_F_REQ, S_F_REL, S_L_REQ, S_L_REL, S_R_REQ, S_R_REL};
  // Count is the number of cycles already spent in this state; the edge that would make it
  // TIMEOUT_CYCLES moves to ERR instead.
  assign w_timeout = w_wait_st && (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_wait_cnt <= '0;
    else if (w_state_nxt != r_state) r_wait_cnt <= '0;
    else if (w_wait_st)              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE:  if (cmd_valid) begin
                 w_accept    = 1'b1;
                 w_state_nxt = S_F_REQ;
               end
      S_F_REQ: if (w_cache_ack_s)  w_state_nxt = S_F_REL;
      S_F_REL: if (!w_cache_ack_s) w_state_nxt = S_L_REQ;
      S_L_REQ: if (w_reg_ack_s)    w_state_nxt = S_L_REL;
      S_L_REL: if (!w_reg_ack_s)   w_state_nxt = S_R_REQ;
      S_R_REQ: if (w_reg_ack_s)    w_state_nxt = S_R_REL;
      S_R_REL: if (!w_reg_ack_s)   w_state_nxt = S_MUL;
      S_MUL:   if (r_mul_cnt == '0) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef SEQ_TIMEOUT_EN
    if (w_timeout && (w_state_nxt == r_state)) w_state_nxt = S_ERR;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Reloaded every cycle outside MUL, so it always enters MUL holding MUL_LAT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_mul_cnt <= '0;
    else if (r_state != S_MUL) r_mul_cnt <= MUL_W'(MUL_LAT - 1);
    else if (r_mul_cnt != '0)  r_mul_cnt <= r_mul_cnt - MUL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra_1 <= '0;
      r_ra_2 <= '0;
      r_wa_1 <= '0;
      r_wa_2 <= '0;
    end else if (w_accept) begin
      r_ra_1 <= cmd_ra_1;
      r_ra_2 <= cmd_ra_2;
      r_wa_1 <= cmd_wa_1;
      r_wa_2 <= cmd_wa_2;
    end
  end

  // Outputs are decoded from the next state so they register in step with the state itself;
  // on the accept edge the addresses come straight from the command bus.
  assign w_ra_1 = w_accept ? cmd_ra_1 : r_ra_1;
  assign w_ra_2 = w_accept ? cmd_ra_2 : r_ra_2;

  always_comb begin
    w_out           = '0;
    w_out.cmd_ready = (w_state_nxt == S_IDLE);
    w_out.busy      = (w_state_nxt != S_IDLE);
    w_out.done      = (w_state_nxt == S_DONE);
`ifdef SEQ_TIMEOUT_EN
    w_out.err       = (w_state_nxt == S_ERR);
`endif
    case (w_state_nxt)
      S_F_REQ, S_F_REL: begin
        w_out.cache_req  = (w_state_nxt == S_F_REQ);
        w_out.cache_re_1 = 1'b1;
        w_out.cache_re_2 = 1'b1;
        w_out.cache_ra_1 = w_ra_1;
        w_out.cache_ra_2 = w_ra_2;
      end
      S_L_REQ, S_L_REL: begin
        w_out.reg_req  = (w_state_nxt == S_L_REQ);
        w_out.reg_we_1 = 1'b1;
        w_out.reg_we_2 = 1'b1;
        w_out.reg_wa_1 = r_wa_1;
        w_out.reg_wa_2 = r_wa_2;
      end
      S_R_REQ, S_R_REL: begin
        w_out.reg_req  = (w_state_nxt == S_R_REQ);
        w_out.reg_re_1 = 1'b1;
        w_out.reg_re_2 = 1'b1;
        w_out.reg_ra_1 = r_wa_1;
        w_out.reg_ra_2 = r_wa_2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out           <= '0;
      r_out.cmd_ready <= 1'b1;
    end else begin
      r_out <= w_out;
    end
  end

  assign cmd_ready  = r_out.cmd_ready;
  assign busy       = r_out.busy;
  assign done       = r_out.done;
  assign err        = r_out.err;
  assign cache_req  = r_out.cache_req;
  assign cache_re_1 = r_out.cache_re_1;
  assign cache_re_2 = r_out.cache_re_2;
  assign cache_ra_1 = r_out.cache_ra_1;
  assign cache_ra_2 = r_out.cache_ra_2;
  assign reg_req    = r_out.reg_req;
  assign reg_we_1   = r_out.reg_we_1;
  assign reg_we_2   = r_out.reg_we_2;
  assign reg_re_1   = r_out.reg_re_1;
  assign reg_re_2   = r_out.reg_re_2;
  assign reg_wa_1   = r_out.reg_wa_1;
  assign reg_wa_2   = r_out.reg_wa_2;
  assign reg_ra_1   = r_out.reg_ra_1;
  assign reg_ra_2   = r_out.reg_ra_2;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed and randomized checks of mul_seq_ctrl against a phase-level model.
// With SEQ_TIMEOUT_EN defined the watchdog scenario is also exercised.
module tb_mul_seq_ctrl;
  localparam int AW = 12;
  localparam int SS = 2;
  localparam int ML = 4;
  localparam int TO = 8;
`ifdef SEQ_TIMEOUT_EN
  localparam int F_STALL = 4;
`else
  localparam int F_STALL = 20;
`endif
  localparam int PH_I = 0, PH_F = 1, PH_L = 2, PH_R = 3, PH_M = 4, PH_D = 5;

  typedef struct packed {
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [3:0]    wa1;
    logic [3:0]    wa2;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_ra_1, cmd_ra_2;
  logic [3:0]    cmd_wa_1, cmd_wa_2;
  logic          cache_req, cache_ack, cache_re_1, cache_re_2;
  logic [AW-1:0] cache_ra_1, cache_ra_2;
  logic          reg_req, reg_ack, reg_we_1, reg_we_2, reg_re_1, reg_re_2;
  logic [3:0]    reg_wa_1, reg_wa_2, reg_ra_1, reg_ra_2;
  logic          busy, done, err;

  int n_assert = 0;
  int n_fail   = 0;
  bit stall_read = 1'b0;

  mul_seq_ctrl #(
    .address_size(AW), .SYNC_STAGES(SS), .MUL_LAT(ML), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ra_1(cmd_ra_1), .cmd_ra_2(cmd_ra_2), .cmd_wa_1(cmd_wa_1), .cmd_wa_2(cmd_wa_2),
    .cache_req(cache_req), .cache_ack(cache_ack), .cache_re_1(cache_re_1), .cache_re_2(cache_re_2),
    .cache_ra_1(cache_ra_1), .cache_ra_2(cache_ra_2),
    .reg_req(reg_req), .reg_ack(reg_ack), .reg_we_1(reg_we_1), .reg_we_2(reg_we_2),
    .reg_re_1(reg_re_1), .reg_re_2(reg_re_2), .reg_wa_1(reg_wa_1), .reg_wa_2(reg_wa_2),
    .reg_ra_1(reg_ra_1), .reg_ra_2(reg_ra_2), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return {14'd0, cmd_ready, busy, done, err, cache_re_1, cache_re_2, cache_ra_1, cache_ra_2,
            reg_we_1, reg_we_2, reg_wa_1, reg_wa_2, reg_re_1, reg_re_2, reg_ra_1, reg_ra_2};
  endfunction

  // Expected non-req outputs for a phase of the sequence, taken from the command itself.
  function automatic logic [63:0] exp_vec(input int ph, input cmd_t c);
    logic fe, le, re;
    fe = (ph == PH_F);
    le = (ph == PH_L);
    re = (ph == PH_R);
    return {14'd0, (ph == PH_I), (ph != PH_I), (ph == PH_D), 1'b0,
            fe, fe, fe ? c.ra1 : {AW{1'b0}}, fe ? c.ra2 : {AW{1'b0}},
            le, le, le ? c.wa1 : 4'd0, le ? c.wa2 : 4'd0,
            re, re, re ? c.wa1 : 4'd0, re ? c.wa2 : 4'd0};
  endfunction

  function automatic int classify();
    if (cache_req || cache_re_1 || cache_re_2) return PH_F;
    if (reg_we_1 || reg_we_2)                  return PH_L;
    if (reg_re_1 || reg_re_2)                  return PH_R;
    if (done)                                  return PH_D;
    if (busy)                                  return PH_M;
    return PH_I;
  endfunction

  // Responder: acks follow the observed req half a cycle later.
  task automatic drive_acks(input bit en_c);
    cache_ack = cache_req & en_c;
    reg_ack   = reg_req & ~(stall_read & reg_re_1);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.ra1 = AW'($urandom);
    c.ra2 = AW'($urandom);
    c.wa1 = 4'($urandom);
    c.wa2 = 4'($urandom);
    return c;
  endfunction

  task automatic run_cmd(input string nm, input cmd_t c, input int f_stall, input bit poke,
                         input bit hold, input bit chk_gap);
    int  gap, n, ph, last, seq;
    int  lenv[6];
    int  reqv[6];
    bit  seen_done;
    cmd_t junk;
    gap = 0;
    do begin
      @(negedge clk);
      drive_acks(1'b1);
      gap++;
    end while (!cmd_ready && gap < 200);
    chk({nm, "_idle_outputs"}, obs_vec(), exp_vec(PH_I, c));
    if (chk_gap) chk({nm, "_b2b_gap"}, gap, 1);
    cmd_ra_1 = c.ra1; cmd_ra_2 = c.ra2; cmd_wa_1 = c.wa1; cmd_wa_2 = c.wa2;
    cmd_valid = 1'b1;
    foreach (lenv[i]) begin lenv[i] = 0; reqv[i] = 0; end
    n = 0; last = -1; seq = 0; seen_done = 1'b0;
    while (!seen_done && n < 400) begin
      @(negedge clk);
      n++;
      if (!hold) cmd_valid = 1'b0;
      if (n == 1) chk({nm, "_accept_latency"}, {62'd0, cache_req, busy}, 64'd3);
      ph = classify();
      if (ph != last) begin
        seq  = seq * 8 + ph;
        last = ph;
      end
      lenv[ph]++;
      if (cache_req || reg_req) reqv[ph]++;
      chk({nm, "_outputs"}, obs_vec(), exp_vec(ph, c));
      if (ph == PH_D) seen_done = 1'b1;
      drive_acks(reqv[PH_F] > f_stall);
      if (poke && !seen_done) begin
        junk = rand_cmd();
        cmd_ra_1 = junk.ra1; cmd_ra_2 = junk.ra2; cmd_wa_1 = junk.wa1; cmd_wa_2 = junk.wa2;
        cmd_valid = 1'($urandom);
      end
    end
    if (!hold) cmd_valid = 1'b0;
    chk({nm, "_done_seen"}, seen_done, 1);
    chk({nm, "_phase_order"}, seq, 32'o12345);
    chk({nm, "_fetch_cycles"}, lenv[PH_F], 2 * (SS + 1) + f_stall);
    chk({nm, "_fetch_req_cycles"}, reqv[PH_F], SS + 1 + f_stall);
    chk({nm, "_load_cycles"}, lenv[PH_L], 2 * (SS + 1));
    chk({nm, "_load_req_cycles"}, reqv[PH_L], SS + 1);
    chk({nm, "_read_cycles"}, lenv[PH_R], 2 * (SS + 1));
    chk({nm, "_read_req_cycles"}, reqv[PH_R], SS + 1);
    chk({nm, "_mul_cycles"}, lenv[PH_M], ML);
    chk({nm, "_done_cycles"}, lenv[PH_D], 1);
    chk({nm, "_req_outside_handshake"}, reqv[PH_M] + reqv[PH_D] + reqv[PH_I], 0);
  endtask

  initial begin
    cmd_t c;
    int   n, dn, rdy;
    rst_n = 1'b0; cmd_valid = 1'b0; cache_ack = 1'b0; reg_ack = 1'b0;
    cmd_ra_1 = '0; cmd_ra_2 = '0; cmd_wa_1 = '0; cmd_wa_2 = '0;
    c = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", obs_vec(), exp_vec(PH_I, c));
    chk("reset_reqs", {cache_req, reg_req}, 0);
    rst_n = 1'b1;

    c.ra1 = 12'h010; c.ra2 = 12'h020; c.wa1 = 4'd3; c.wa2 = 4'd5;
    run_cmd("directed", c, 0, 1'b0, 1'b0, 1'b0);
    run_cmd("stall", rand_cmd(), F_STALL, 1'b0, 1'b0, 1'b0);
    run_cmd("ignored_inputs", rand_cmd(), 0, 1'b1, 1'b0, 1'b0);

    // Reset while the register load handshake is in progress.
    c = rand_cmd();
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
    cmd_ra_1 = c.ra1; cmd_ra_2 = c.ra2; cmd_wa_1 = c.wa1; cmd_wa_2 = c.wa2;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      drive_acks(1'b1);
      n++;
    end while (!(reg_req && reg_we_1) && n < 100);
    chk("midrst_reached_load", {reg_req, reg_we_1, reg_we_2}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_async_drop", {reg_req, reg_we_1, reg_we_2, busy, cmd_ready}, 5'b00001);
    cache_ack = 1'b0; reg_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0; rdy = 0;
    repeat (20) begin
      @(negedge clk);
      drive_acks(1'b1);
      if (done) dn++;
      if (cmd_ready) rdy++;
    end
    chk("midrst_no_done", dn, 0);
    chk("midrst_ready_after_release", rdy, 20);

    for (int k = 0; k < 4; k++) run_cmd("random", rand_cmd(), 0, 1'($urandom), 1'b0, 1'b0);

    run_cmd("b2b_1", rand_cmd(), 0, 1'b0, 1'b1, 1'b0);
    run_cmd("b2b_2", rand_cmd(), 0, 1'b0, 1'b1, 1'b1);
    run_cmd("b2b_3", rand_cmd(), 0, 1'b0, 1'b0, 1'b1);

`ifdef SEQ_TIMEOUT_EN
    stall_read = 1'b1;
    c = rand_cmd();
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
    cmd_ra_1 = c.ra1; cmd_ra_2 = c.ra2; cmd_wa_1 = c.wa1; cmd_wa_2 = c.wa2;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      drive_acks(1'b1);
      n++;
    end while (!(reg_req && reg_re_1) && n < 200);
    chk("tmo_reached_read", {reg_req, reg_re_1}, 2'b11);
    n = 0; dn = 0;
    do begin
      @(negedge clk);
      drive_acks(1'b1);
      if (done) dn++;
      n++;
    end while (!err && n < 50);
    chk("tmo_err_delay", n, TO);
    chk("tmo_outputs_in_err", {reg_req, reg_re_1, reg_re_2, cache_req, err}, 5'b00001);
    @(negedge clk);
    chk("tmo_back_to_idle", {err, cmd_ready, busy}, 3'b010);
    chk("tmo_no_done", dn, 0);
    stall_read = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Synchronous sequencer for the cache → register file → multiplier datapath. Accepts one multiply command at a time and runs three four-phase req/ack handshakes: cache fetch of two operands, register write of the operands, and register read into the multiplier. It then waits the multiplier latency and signals completion. Ack inputs come from the asynchronous blocks and are synchronized internally.

## Interface
- `address_size`, 12, cache address width
- `SYNC_STAGES`, 2, flops in each ack synchronizer (≥2)
- `MUL_LAT`, 4, cycles spent in MUL before done (≥1)
- `TIMEOUT_CYCLES`, 255, watchdog limit per handshake wait state (used only with `SEQ_TIMEOUT_EN`)

Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.

- `clk` in 1 — clock
- `rst_n` in 1 — async active-low reset
- `cmd_valid` in 1 — command offered
- `cmd_ready` out 1 — high only in IDLE
- `cmd_ra_1`, `cmd_ra_2` in address_size — cache addresses of operands Rm, Rs
- `cmd_wa_1`, `cmd_wa_2` in 4 — register slots for Rm, Rs
- `cache_req` out 1, `cache_ack` in 1 — cache handshake
- `cache_re_1`, `cache_re_2` out 1; `cache_ra_1`, `cache_ra_2` out address_size
- `reg_req` out 1, `reg_ack` in 1 — register handshake
- `reg_we_1`, `reg_we_2`, `reg_re_1`, `reg_re_2` out 1; `reg_wa_1`, `reg_wa_2`, `reg_ra_1`, `reg_ra_2` out 4
- `busy` out 1 — state ≠ IDLE
- `done` out 1 — one-cycle pulse when the result is valid
- `err` out 1 — one-cycle timeout pulse; tied 0 without `SEQ_TIMEOUT_EN`

## Operation
- **Command accept:** a command is accepted when `cmd_valid` and `cmd_ready` are both high. All `cmd_*` fields are captured into internal registers. Inputs are ignored while busy.
- **States:** IDLE → F_REQ → F_REL → L_REQ → L_REL → R_REQ → R_REL → MUL → DONE → IDLE. ERR exists only with the macro.
- **F_REQ / F_REL (fetch):**
  - Drive `cache_re_1` = `cache_re_2` = 1 and `cache_ra_1`/`cache_ra_2` = captured addresses.
  - F_REQ: `cache_req` = 1; go to F_REL on the cycle the synced `cache_ack` = 1.
  - F_REL: `cache_req` = 0 with controls still held; go to L_REQ on the cycle the synced `cache_ack` = 0.
- **L_REQ / L_REL (load):** same handshake on `reg_req`/`reg_ack`, with `reg_we_1` = `reg_we_2` = 1 and `reg_wa_*` = captured slots.
- **R_REQ / R_REL (read):** same handshake, with `reg_re_1` = `reg_re_2` = 1 and `reg_ra_*` = captured slots.
- **Control stability:** all enables and addresses of a phase are valid from req rise until the cycle the state leaves X_REL. They are 0 in every other state.
- **MUL:** a down-counter is loaded with MUL_LAT−1 on entry. Leave MUL when it reaches 0; the state occupies exactly MUL_LAT cycles.
- **DONE:** `done` = 1 for one cycle, then IDLE. `cmd_ready` rises the following cycle.
- **Ack synchronizers:** separate SYNC_STAGES-deep chains for `cache_ack` and `reg_ack`. The FSM uses only the synchronized values.
- **Ack already high:** an ack that is already high when entering X_REQ is honored immediately. An ack still high on entering the next X_REQ is a protocol error by the environment; no special handling.

## Timing
- All outputs are registered, decoded from state and the captured command.
- **Reset values:** `cmd_ready` = 1; every other output = 0. State = IDLE, synchronizers and counters = 0.
- **Reset mid-operation:** req and all enables drop to 0 asynchronously. The captured command is discarded and there is no `done`.
- **Accept latency:** accept edge N → F_REQ (`cache_req` = 1, `busy` = 1) at N+1.
- **Handshake latency:** the environment's ack edge becomes visible to the FSM after SYNC_STAGES cycles. The state transition occurs at the next edge after that.
- **Back-to-back commands:** `cmd_valid` held high yields a new acceptance on the first cycle of IDLE after DONE. Minimum gap between `done` pulses = 1 IDLE cycle + full sequence.

## Configuration
- **`SEQ_TIMEOUT_EN` defined:**
  - A wait counter clears on each state change and increments in F_REQ, F_REL, L_REQ, L_REL, R_REQ and R_REL.
  - When the count reaches TIMEOUT_CYCLES, go to ERR.
  - ERR: all req and enables = 0 and `err` = 1 for one cycle, then IDLE.
- **Not defined:** no counter and no ERR state; `err` is constant 0. Wait states may hang indefinitely.

## Test plan
- **Reset then one command:**
  - Stimulus: ra = 0x010/0x020, wa = 3/5; the responder acks 1 cycle after seeing req and drops ack 1 cycle after req falls.
  - Required: exact address/enable values in each phase, one `done` pulse, MUL lasts exactly 4 cycles.
- **Stability check:** hold `cache_ack` low for 20 cycles in F_REQ → `cache_req` and `cache_ra_*` stay constant; no state advance.
- **Ignored inputs:** change `cmd_*` and pulse `cmd_valid` while busy → ignored; the outputs still show the captured values.
- **Reset mid-operation:** assert `rst_n` = 0 during L_REQ → `reg_req`/`reg_we_*` drop to 0 immediately, `cmd_ready` = 1 after release, no `done`.
- **Back-to-back commands:** 3 commands with `cmd_valid` held high → 3 `done` pulses, each separated by ≥1 `cmd_ready` cycle, in order.
- **Timeout (`SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES = 8):** never ack `reg_req` in R_REQ → `err` pulses once 8 cycles after R_REQ entry, `reg_req` = 0, return to IDLE, no `done`.
